aes_sub_lanes: RTL and testbench
================================

Name: aes_sub_lanes

Overview:
- Parametrised, pipelined AES byte-substitution engine for the tiny_aes datapath.
- Performs three functions on N_LANES input bytes per beat: forward S-box, inverse S-box, or T-column expansion {S, S, 3·S, 2·S}.
- S-box values are computed arithmetically (GF(2^8) multiplicative inverse plus affine transform) rather than stored, so one block serves both encrypt and decrypt cores.
- Two-stage elastic pipeline with valid/ready handshakes on both sides and full throughput. A sideband tag travels with each beat.

Parameters:
- N_LANES, 4, number of independent byte lanes per beat (1..16).
- TAG_W, 4, width of the sideband tag carried alongside each beat (≥1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_mode  in  2  00 = SUB, 01 = INV, 10 = TCOL, 11 = reserved (treated as SUB).
- in_data  in  8*N_LANES  lane i = in_data[8i+7:8i].
- in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32*N_LANES  lane i = out_data[32i+31:32i].
- out_tag  out  TAG_W  tag of the current result beat.

Behaviour:
- Clocking and reset: clk, with reset as a synchronous, active-high reset. While reset is high at a rising edge, both stage valids clear and out_data, out_tag and all stage data registers are set to 0. In-flight beats are discarded. in_ready is high in the first cycle after reset deasserts.
- Reset outputs: out_valid=0, out_data=0, out_tag=0.
- Transfer rule: a transfer occurs on any edge where valid && ready.
- Ready and advance:
  - s2_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_adv, combinational.
  - in_ready never depends on in_valid.
- Stage 1, loaded on input transfer:
  - Per lane, x' = inverse affine of x for INV, otherwise x' = x.
  - Register inv(x'), the GF(2^8) inverse mod 0x11B, with inv(0) = 0.
  - Mode and tag are registered alongside.
- Stage 2, loaded when s1_valid && s2_adv:
  - Per lane, let b = stage-1 byte.
  - SUB: s = affine(b) (matrix plus 0x63); lane word = {24'h0, s}.
  - INV: lane word = {24'h0, b}.
  - TCOL: s = affine(b), d = xtime(s) = (s<<1) ^ (s[7] ? 0x1B : 0), t = s ^ d; lane word = {s, s, t, d} with s in bits 31:24 and d in bits 7:0.
- Valid bookkeeping:
  - s1_valid is set on input transfer, otherwise cleared when stage 1 advances.
  - s2_valid is set when stage 1 advances, otherwise cleared on output transfer.
- Latency and throughput:
  - A beat accepted at edge k is presented on out_valid/out_data after edge k+1, i.e. two register stages.
  - Throughput is one beat per cycle while out_ready stays high.
- Stall: with out_ready low, out_data and out_tag hold stable. The pipeline absorbs at most 2 beats, then in_ready goes low.
- Simultaneous events: an output transfer, a stage-1 advance and an input transfer may all occur in the same cycle with no bubble.
- Mode is sampled per beat. Mixing modes on consecutive beats is legal and causes no flush.
- Lanes are fully independent. There is no cross-lane arithmetic.
- out_data is meaningful only while out_valid=1. It holds its last value otherwise, and is 0 after reset.
- Protocol rules on out_* and assertions:
  - Once out_valid is asserted it stays high, with data stable, until the output transfer.
  - An assertion checks this rule.
  - An assertion checks that an in_mode of 11 never produces any result other than the SUB result.

Test Plan:
- Reset: hold reset 3 cycles mid-stream with 2 beats in flight -> out_valid=0, out_data=0 after the reset edge; in_ready=1 the cycle after reset deasserts; the dropped beats never appear.
- SUB, N_LANES=4: in_data=32'h5301_0000, lanes 0..3 = {00, 00, 01, 53} -> lane words 0x63, 0x63, 0x7C, 0xED, low bytes only, upper 24 bits 0; out_valid exactly 2 edges after acceptance.
- INV: in_data bytes {63, 63, 7C, ED} -> lane low bytes {00, 00, 01, 53}. Exhaustive sweep of all 256 bytes through SUB then INV returns the identity.
- TCOL: lane byte 0x00 -> 32'h6363A5C6; 0x01 -> 32'h7C7C84F8; 0x53 -> {ED, ED, 2C, C1}, checked against the software model.
- Backpressure: out_ready=0 while pushing 3 beats with tags 1, 2, 3 -> tags 1 and 2 accepted, in_ready=0 before beat 3; release out_ready -> tags emerge 1, 2, 3 in order, data unchanged during the stall, one beat per cycle.
- Streaming: 100 random beats with random modes, in_valid toggling and out_ready toggling -> results and tags match a scoreboard in order, no drops or duplicates, full throughput whenever both sides are continuously ready.

Source files
------------

// File: rtl/aes_sub_lanes_if.sv
// Handshake and data bundle for the aes_sub_lanes engine.
// The master side feeds input beats and accepts results. The slave side is the engine.
interface aes_sub_lanes_if #(
   parameter int N_LANES = 4,
   parameter int TAG_W   = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            in_mode;
   logic [8*N_LANES-1:0]  in_data;
   logic [TAG_W-1:0]      in_tag;
   logic                  out_valid;
   logic                  out_ready;
   logic [32*N_LANES-1:0] out_data;
   logic [TAG_W-1:0]      out_tag;

   modport master (
      output in_valid, in_mode, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_mode, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/aes_sub_lanes.sv
// Two-stage elastic AES byte-substitution engine.
// Stage 1 registers the GF(2^8) inverse of each lane byte. For INV mode the inverse affine
// transform is applied first. Stage 2 applies the forward affine transform (SUB/TCOL) or
// passes the inverse through (INV), and builds the 32-bit lane word.
module aes_sub_lanes #(
   parameter int N_LANES = 4,
   parameter int TAG_W   = 4
) (
   input  logic          clk,
   input  logic          reset,
   aes_sub_lanes_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_SUB  = 2'b00,
      MODE_INV  = 2'b01,
      MODE_TCOL = 2'b10,
      MODE_RSV  = 2'b11
   } mode_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] a, input int unsigned k);
      return (a << k) | (a >> (8 - k));
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 without a special case.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_affine(input logic [7:0] y);
      return rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05;
   endfunction

   logic                  s1_valid_q, s1_valid_d;
   logic [8*N_LANES-1:0]  s1_data_q, s1_data_d;
   mode_e                 s1_mode_q, s1_mode_d;
   logic [TAG_W-1:0]      s1_tag_q, s1_tag_d;

   logic                  s2_valid_q, s2_valid_d;
   logic [32*N_LANES-1:0] s2_data_q, s2_data_d;
   logic [TAG_W-1:0]      s2_tag_q, s2_tag_d;

   logic                  s2_adv;
   logic                  in_rdy;
   logic                  in_fire;
   logic                  s1_adv;
   logic                  out_fire;

   logic [7:0]            s1_lane_x;
   logic [7:0]            s2_lane_b;
   logic [7:0]            s2_lane_s;
   logic [7:0]            s2_lane_d;
   logic [32*N_LANES-1:0] sub_word;

   assign s2_adv   = !s2_valid_q || bus.out_ready;
   assign in_rdy   = !s1_valid_q || s2_adv;
   assign in_fire  = bus.in_valid && in_rdy;
   assign s1_adv   = s1_valid_q && s2_adv;
   assign out_fire = s2_valid_q && bus.out_ready;

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_data  = s2_data_q;
   assign bus.out_tag   = s2_tag_q;

   // Stage 1 next state: capture per-lane GF inverse, mode and tag on input transfer.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_mode_d  = s1_mode_q;
      s1_tag_d   = s1_tag_q;
      s1_lane_x  = 8'h00;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_mode_d  = mode_e'(bus.in_mode);
         s1_tag_d   = bus.in_tag;
         for (int i = 0; i < N_LANES; i++) begin
            // NOTE: blocking assignment is right here; the temporary is consumed within this pass.
            s1_lane_x = bus.in_data[8*i +: 8];
            if (mode_e'(bus.in_mode) == MODE_INV) s1_lane_x = inv_affine(s1_lane_x);
            s1_data_d[8*i +: 8] = gf_inv(s1_lane_x);
         end
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   // Stage 2 next state: build each lane word from the stage-1 inverse when stage 1 advances.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_tag_d   = s2_tag_q;
      sub_word   = '0;
      s2_lane_b  = 8'h00;
      s2_lane_s  = 8'h00;
      s2_lane_d  = 8'h00;
      for (int i = 0; i < N_LANES; i++) begin
         s2_lane_b = s1_data_q[8*i +: 8];
         s2_lane_s = affine(s2_lane_b);
         s2_lane_d = xtime(s2_lane_s);
         sub_word[32*i +: 32] = {24'h0, s2_lane_s};
         if (s1_adv) begin
            case (s1_mode_q)
               MODE_INV:  s2_data_d[32*i +: 32] = {24'h0, s2_lane_b};
               MODE_TCOL: s2_data_d[32*i +: 32] = {s2_lane_s, s2_lane_s, s2_lane_s ^ s2_lane_d, s2_lane_d};
               default:   s2_data_d[32*i +: 32] = {24'h0, s2_lane_s};
            endcase
         end
      end
      if (s1_adv) begin
         s2_valid_d = 1'b1;
         s2_tag_d   = s1_tag_q;
      end else if (out_fire) begin
         s2_valid_d = 1'b0;
      end
   end

   // Stage 1 registers; reset discards any beat in flight.
   always_ff @(posedge clk) begin
      // NOTE: data registers are cleared on reset as well, so out_data reads 0 after reset.
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= MODE_SUB;
         s1_tag_q   <= '0;
      end else begin
         // NOTE: non-blocking for all state so every register samples pre-edge values.
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_mode_q  <= s1_mode_d;
         s1_tag_q   <= s1_tag_d;
      end
   end

   // Stage 2 registers drive the result interface directly.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_tag_q   <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   // A presented result must hold, unchanged, until it is taken.
   a_out_hold: assert property (@(posedge clk) disable iff (reset)
      (s2_valid_q && !bus.out_ready) |=> (s2_valid_q && $stable(s2_data_q) && $stable(s2_tag_q)));

   // The reserved mode encoding must behave exactly like SUB.
   a_rsv_is_sub: assert property (@(posedge clk) disable iff (reset)
      (s1_adv && s1_mode_q == MODE_RSV) |=> (s2_data_q == $past(sub_word)));

endmodule

// File: tb/tb_aes_sub_lanes.sv
// Directed and scoreboard bench for aes_sub_lanes (4 lanes, 4-bit tag).
// The reference uses the published AES S-box table, independent of the arithmetic datapath.
module tb_aes_sub_lanes;
   localparam int N_LANES = 4;
   localparam int TAG_W   = 4;
   localparam int DW      = 8 * N_LANES;
   localparam int OW      = 32 * N_LANES;

   logic clk = 1'b0;
   logic reset;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   aes_sub_lanes_if #(.N_LANES(N_LANES), .TAG_W(TAG_W)) bus ();

   aes_sub_lanes #(.N_LANES(N_LANES), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] sbox_tbl [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      logic [7:0] r;
      r = 8'h00;
      for (int x = 0; x < 256; x++) if (sbox_tbl[x] == y) r = 8'(x);
      return r;
   endfunction

   function automatic logic [OW-1:0] model(input logic [1:0] mode, input logic [DW-1:0] d);
      logic [OW-1:0] r;
      logic [7:0]    b, s, dd;
      r = '0;
      for (int i = 0; i < N_LANES; i++) begin
         b  = d[8*i +: 8];
         s  = sbox_tbl[b];
         dd = {s[6:0], 1'b0} ^ (s[7] ? 8'h1B : 8'h00);
         case (mode)
            2'b01:   r[32*i +: 32] = {24'h0, inv_sbox(b)};
            2'b10:   r[32*i +: 32] = {s, s, s ^ dd, dd};
            default: r[32*i +: 32] = {24'h0, s};
         endcase
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pushes one beat into an empty pipeline with out_ready high and returns the result.
   // lat_ok is set when the result appears exactly after the second edge from acceptance.
   task automatic single_beat(input logic [1:0] m, input logic [DW-1:0] d, input logic [TAG_W-1:0] t,
                              output bit lat_ok, output logic [OW-1:0] q, output logic [TAG_W-1:0] qt);
      bus.in_valid  = 1'b1;
      bus.in_mode   = m;
      bus.in_data   = d;
      bus.in_tag    = t;
      bus.out_ready = 1'b1;
      #1;
      lat_ok = (bus.in_ready === 1'b1) && (bus.out_valid === 1'b0);
      tick();
      bus.in_valid = 1'b0;
      #1;
      lat_ok = lat_ok && (bus.out_valid === 1'b0);
      tick();
      #1;
      lat_ok = lat_ok && (bus.out_valid === 1'b1);
      q  = bus.out_data;
      qt = bus.out_tag;
      tick();
   endtask

   task automatic test_reset();
      bit saw_valid;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_mode   = 2'b00;
      bus.in_data   = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      #1;
      n_total++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL por_out_valid: got %b want 0", bus.out_valid); end
      n_total++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL por_out_data: got %h want 0", bus.out_data); end
      n_total++; if (bus.out_tag !== '0) begin n_bad++; $display("FAIL por_out_tag: got %h want 0", bus.out_tag); end
      reset = 1'b0;
      #1;
      n_total++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL por_in_ready: got %b want 1", bus.in_ready); end
      tick();
      // Two beats in flight with the output stalled, then a mid-stream reset.
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h11223344;
      bus.in_tag   = 4'd5;
      tick();
      bus.in_data  = 32'h55667788;
      bus.in_tag   = 4'd6;
      tick();
      bus.in_valid = 1'b0;
      #1;
      n_total++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %b want 1", bus.out_valid); end
      reset = 1'b1;
      tick();
      #1;
      n_total++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_total++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
      tick();
      tick();
      reset = 1'b0;
      #1;
      n_total++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
      bus.out_ready = 1'b1;
      saw_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         #1;
         if (bus.out_valid !== 1'b0) saw_valid = 1'b1;
      end
      n_total++; if (saw_valid) begin n_bad++; $display("FAIL rst_dropped_beats: out_valid seen=1 want 0"); end
      bus.out_ready = 1'b0;
      tick();
   endtask

   task automatic test_sub();
      bit               ok;
      logic [OW-1:0]    q;
      logic [TAG_W-1:0] qt;
      single_beat(2'b00, 32'h5301_0000, 4'hA, ok, q, qt);
      n_total++; if (!ok) begin n_bad++; $display("FAIL sub_latency: got bad timing want 2-edge latency"); end
      n_total++; if (q !== 128'h000000ED_0000007C_00000063_00000063) begin n_bad++; $display("FAIL sub_data: got %h want %h", q, 128'h000000ED_0000007C_00000063_00000063); end
      n_total++; if (qt !== 4'hA) begin n_bad++; $display("FAIL sub_tag: got %h want a", qt); end
   endtask

   task automatic test_inv();
      bit               ok;
      logic [OW-1:0]    q;
      logic [TAG_W-1:0] qt;
      single_beat(2'b01, 32'hED7C_6363, 4'h3, ok, q, qt);
      n_total++; if (!ok) begin n_bad++; $display("FAIL inv_latency: got bad timing want 2-edge latency"); end
      n_total++; if (q !== 128'h00000053_00000001_00000000_00000000) begin n_bad++; $display("FAIL inv_data: got %h want %h", q, 128'h00000053_00000001_00000000_00000000); end
      n_total++; if (qt !== 4'h3) begin n_bad++; $display("FAIL inv_tag: got %h want 3", qt); end
   endtask

   task automatic test_tcol();
      bit               ok;
      logic [OW-1:0]    q;
      logic [TAG_W-1:0] qt;
      single_beat(2'b10, 32'h0053_0100, 4'h7, ok, q, qt);
      n_total++; if (!ok) begin n_bad++; $display("FAIL tcol_latency: got bad timing want 2-edge latency"); end
      n_total++; if (q !== 128'h6363A5C6_EDED2CC1_7C7C84F8_6363A5C6) begin n_bad++; $display("FAIL tcol_data: got %h want %h", q, 128'h6363A5C6_EDED2CC1_7C7C84F8_6363A5C6); end
      n_total++; if (q !== model(2'b10, 32'h0053_0100)) begin n_bad++; $display("FAIL tcol_model: got %h want %h", q, model(2'b10, 32'h0053_0100)); end
      n_total++; if (qt !== 4'h7) begin n_bad++; $display("FAIL tcol_tag: got %h want 7", qt); end
   endtask

   task automatic test_reserved();
      bit               ok;
      logic [OW-1:0]    q;
      logic [TAG_W-1:0] qt;
      single_beat(2'b11, 32'h5301_0000, 4'hF, ok, q, qt);
      n_total++; if (!ok || q !== 128'h000000ED_0000007C_00000063_00000063) begin n_bad++; $display("FAIL rsv_as_sub: got %h want %h", q, 128'h000000ED_0000007C_00000063_00000063); end
   endtask

   task automatic test_sweep();
      bit               ok;
      logic [OW-1:0]    q, exp;
      logic [TAG_W-1:0] qt;
      logic [DW-1:0]    d, b;
      for (int j = 0; j < 64; j++) begin
         d = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
         single_beat(2'b00, d, 4'(j), ok, q, qt);
         n_total++; if (!ok || q !== model(2'b00, d)) begin n_bad++; $display("FAIL sweep_sub in=%h: got %h want %h", d, q, model(2'b00, d)); end
         b = {q[103:96], q[71:64], q[39:32], q[7:0]};
         single_beat(2'b01, b, 4'(j), ok, q, qt);
         exp = {24'h0, d[31:24], 24'h0, d[23:16], 24'h0, d[15:8], 24'h0, d[7:0]};
         n_total++; if (!ok || q !== exp) begin n_bad++; $display("FAIL sweep_inv in=%h: got %h want %h", b, q, exp); end
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0]    din [3];
      logic [OW-1:0]    snap_d;
      logic [TAG_W-1:0] snap_t;
      bit               stable;
      din[0] = 32'h03020100;
      din[1] = 32'h07060504;
      din[2] = 32'h0B0A0908;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_mode   = 2'b00;
      for (int k = 0; k < 2; k++) begin
         bus.in_data = din[k];
         bus.in_tag  = 4'(k + 1);
         #1;
         n_total++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept_%0d: in_ready got %b want 1", k + 1, bus.in_ready); end
         tick();
      end
      bus.in_data = din[2];
      bus.in_tag  = 4'd3;
      #1;
      n_total++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: in_ready got %b want 0", bus.in_ready); end
      n_total++; if (bus.out_tag !== 4'd1 || bus.out_data !== model(2'b00, din[0])) begin n_bad++; $display("FAIL bp_head: got tag %h data %h want tag 1 data %h", bus.out_tag, bus.out_data, model(2'b00, din[0])); end
      snap_d = bus.out_data;
      snap_t = bus.out_tag;
      stable = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         #1;
         if (bus.out_data !== snap_d || bus.out_tag !== snap_t || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
      end
      n_total++; if (!stable) begin n_bad++; $display("FAIL bp_stall_hold: got data %h tag %h want %h tag %h", bus.out_data, bus.out_tag, snap_d, snap_t); end
      bus.out_ready = 1'b1;
      #1;
      n_total++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'(k + 1) || bus.out_data !== model(2'b00, din[k])) begin
            n_bad++;
            $display("FAIL bp_drain_%0d: got v=%b tag %h data %h want v=1 tag %0d data %h", k, bus.out_valid, bus.out_tag, bus.out_data, k + 1, model(2'b00, din[k]));
         end
         tick();
         if (k == 0) bus.in_valid = 1'b0;
         #1;
      end
      n_total++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: out_valid got %b want 0", bus.out_valid); end
      bus.out_ready = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [OW+TAG_W-1:0] sb [$];
      logic [OW+TAG_W-1:0] exp;
      int  sent, got, cyc;
      bit  pend;
      sent = 0; got = 0; cyc = 0; pend = 1'b0;
      // Random phase: both sides toggle, tags and modes random.
      while ((sent < 100 || got < 100) && cyc < 3000) begin
         if (!pend && sent < 100 && $urandom_range(0, 3) != 0) begin
            pend        = 1'b1;
            bus.in_mode = 2'($urandom);
            bus.in_data = $urandom;
            bus.in_tag  = 4'($urandom);
         end
         bus.in_valid  = pend;
         bus.out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back({model(bus.in_mode, bus.in_data), bus.in_tag});
            sent++;
            pend = 1'b0;
         end
         if (bus.out_valid && bus.out_ready) begin
            n_total++;
            if (sb.size() == 0) begin
               n_bad++; $display("FAIL stream_extra: got tag %h with empty scoreboard", bus.out_tag);
            end else begin
               exp = sb.pop_front();
               if ({bus.out_data, bus.out_tag} !== exp) begin n_bad++; $display("FAIL stream_beat_%0d: got %h want %h", got, {bus.out_data, bus.out_tag}, exp); end
            end
            got++;
         end
         tick();
         cyc++;
      end
      n_total++; if (got != 100 || sb.size() != 0) begin n_bad++; $display("FAIL stream_count: got %0d beats (%0d pending) want 100 (0)", got, sb.size()); end
      // Continuous phase: both sides always ready, one beat every cycle.
      bus.out_ready = 1'b1;
      for (int c = 0; c < 22; c++) begin
         bus.in_valid = (c < 20);
         bus.in_mode  = 2'(c);
         bus.in_data  = $urandom;
         bus.in_tag   = 4'(c);
         #1;
         if (c < 20) begin
            n_total++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready_%0d: got %b want 1", c, bus.in_ready); end
            if (bus.in_ready) sb.push_back({model(bus.in_mode, bus.in_data), bus.in_tag});
         end
         if (c >= 2) begin
            n_total++;
            if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
               n_bad++; $display("FAIL b2b_bubble_%0d: out_valid got %b want 1", c, bus.out_valid);
            end else begin
               exp = sb.pop_front();
               if ({bus.out_data, bus.out_tag} !== exp) begin n_bad++; $display("FAIL b2b_beat_%0d: got %h want %h", c, {bus.out_data, bus.out_tag}, exp); end
            end
         end
         tick();
      end
      bus.in_valid = 1'b0;
      #1;
      n_total++; if (bus.out_valid !== 1'b0 || sb.size() != 0) begin n_bad++; $display("FAIL b2b_drain: out_valid got %b pending %0d want 0 0", bus.out_valid, sb.size()); end
      bus.out_ready = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_sub();
      test_inv();
      test_tcol();
      test_reserved();
      test_sweep();
      test_backpressure();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
